// File: rtl/seg7_frame_decoder.sv
// Read-back decoder for a multiplexed 7-segment bus: samples each digit once it has been
// steady, converts the pattern to BCD and presents whole frames on valid/ready.
// Optional macro SEG7_ALT_GLYPH_EN accepts alternate 6/7/9 glyphs.
module seg7_frame_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     err_glyph,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [DIGITS-1:0]   prev_an_reg;
  logic [6:0]          prev_seg_reg;
  logic [7:0]          cnt_reg;
  logic [7:0]          cnt_next;
  logic                qualified;
  logic                changed;
  logic                sample;

  logic [3:0]          glyph_nibble;
  logic                glyph_err;

  logic [DIGITS-1:0]   seen_reg;
  logic [DIGITS-1:0]   seen_set;
  logic [4*DIGITS-1:0] work_bcd_reg;
  logic [4*DIGITS-1:0] work_bcd_next;
  logic [DIGITS-1:0]   work_err_reg;
  logic [DIGITS-1:0]   work_err_next;
  logic                complete;
  logic                slot_free;

  logic [4*DIGITS-1:0] bcd_reg;
  logic [DIGITS-1:0]   err_reg;
  logic                valid_reg;
  logic                overflow_reg;

  assign qualified = $onehot(an);
  assign changed   = (an != prev_an_reg) || (seg != prev_seg_reg);

  // The counter saturates, so the sample fires only on the cycle it first reaches the
  // target; a fresh change is needed before the same digit can be sampled again.
  always_comb begin
    cnt_next = cnt_reg;
    if (!qualified) begin
      cnt_next = 8'd0;
    end else if (changed) begin
      cnt_next = 8'd1;
    end else if (cnt_reg < STABLE) begin
      cnt_next = cnt_reg + 8'd1;
    end
  end

  assign sample = qualified && (cnt_next == STABLE) && (changed || (cnt_reg != STABLE));

  always_comb begin
    glyph_nibble = 4'hF;
    glyph_err    = 1'b0;
    case (seg)
      7'b1111110: glyph_nibble = 4'd0;
      7'b0110000: glyph_nibble = 4'd1;
      7'b1101101: glyph_nibble = 4'd2;
      7'b1111001: glyph_nibble = 4'd3;
      7'b0110011: glyph_nibble = 4'd4;
      7'b1011011: glyph_nibble = 4'd5;
      7'b1011111: glyph_nibble = 4'd6;
      7'b1110000: glyph_nibble = 4'd7;
      7'b1111111: glyph_nibble = 4'd8;
      7'b1111011: glyph_nibble = 4'd9;
`ifdef SEG7_ALT_GLYPH_EN
      7'b0011111: glyph_nibble = 4'd6;
      7'b1110010: glyph_nibble = 4'd7;
      7'b1110011: glyph_nibble = 4'd9;
`endif
      default: begin
        glyph_nibble = 4'hF;
        glyph_err    = 1'b1;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign seen_set[gi]              = seen_reg[gi] | (sample & an[gi]);
      assign work_bcd_next[4*gi +: 4]  = (sample && an[gi]) ? glyph_nibble : work_bcd_reg[4*gi +: 4];
      assign work_err_next[gi]         = (sample && an[gi]) ? glyph_err : work_err_reg[gi];
    end
  endgenerate

  assign complete  = sample && (&seen_set) && !(&seen_reg);
  assign slot_free = !valid_reg || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_an_reg  <= '0;
      prev_seg_reg <= '0;
      cnt_reg      <= '0;
      seen_reg     <= '0;
      work_bcd_reg <= '0;
      work_err_reg <= '0;
      bcd_reg      <= '0;
      err_reg      <= '0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      prev_an_reg  <= an;
      prev_seg_reg <= seg;
      cnt_reg      <= cnt_next;
      work_bcd_reg <= work_bcd_next;
      work_err_reg <= work_err_next;
      if (complete) begin
        seen_reg <= '0;
        if (slot_free) begin
          bcd_reg   <= work_bcd_next;
          err_reg   <= work_err_next;
          valid_reg <= 1'b1;
        end else begin
          overflow_reg <= 1'b1;
        end
      end else begin
        seen_reg <= seen_set;
        if (valid_reg && out_ready) begin
          valid_reg <= 1'b0;
        end
      end
    end
  end

  assign bcd_out   = bcd_reg;
  assign err_glyph = err_reg;
  assign out_valid = valid_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Bench for seg7_frame_decoder: directed vector table, hand-written glyph sequence and
// randomized traffic checked every cycle against a run-length based reference model.
module tb_seg7_frame_decoder;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  localparam logic [6:0] G0 = 7'b1111110, G1 = 7'b0110000, G2 = 7'b1101101, G3 = 7'b1111001;
  localparam logic [6:0] G4 = 7'b0110011, G5 = 7'b1011011, G6 = 7'b1011111, G7 = 7'b1110000;
  localparam logic [6:0] G8 = 7'b1111111, G9 = 7'b1111011;
  localparam logic [6:0] A6 = 7'b0011111, A7 = 7'b1110010, A9 = 7'b1110011, BADG = 7'b0000001;
  localparam logic [6:0] GLYPH [10] = '{G0, G1, G2, G3, G4, G5, G6, G7, G8, G9};
  localparam logic [6:0] POOL [14] = '{G0, G1, G2, G3, G4, G5, G6, G7, G8, G9, A6, A7, A9, BADG};

  logic                  clk = 1'b0;
  logic                  rst;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     an;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [DIGITS-1:0]     err_glyph;
  logic                  out_valid;
  logic                  out_ready;
  logic                  overflow;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b1;

  seg7_frame_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an), .bcd_out(bcd_out), .err_glyph(err_glyph),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model state: length of the current steady run plus the frame being gathered.
  int                   run_len;
  logic [DIGITS-1:0]    last_an;
  logic [6:0]           last_seg;
  logic [3:0]           m_nib [DIGITS];
  logic [DIGITS-1:0]    m_err;
  logic [DIGITS-1:0]    m_seen;
  logic                 exp_valid;
  logic                 exp_ovf;
  logic [4*DIGITS-1:0]  exp_bcd;
  logic [DIGITS-1:0]    exp_err;

  function automatic void ref_decode(input logic [6:0] s, output logic [3:0] n, output logic e);
    n = 4'hF;
    e = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (s == GLYPH[i]) begin
        n = 4'(i);
        e = 1'b0;
      end
    end
`ifdef SEG7_ALT_GLYPH_EN
    if (s == A6) begin n = 4'd6; e = 1'b0; end
    if (s == A7) begin n = 4'd7; e = 1'b0; end
    if (s == A9) begin n = 4'd9; e = 1'b0; end
`endif
  endfunction

  task automatic model_step();
    logic [3:0] nib;
    logic       e;
    int         d;
    bit         hs, loaded, smp;
    if (rst) begin
      run_len = 0; last_an = '0; last_seg = '0; m_seen = '0; m_err = '0;
      for (int i = 0; i < DIGITS; i++) m_nib[i] = 4'h0;
      exp_valid = 1'b0; exp_ovf = 1'b0; exp_bcd = '0; exp_err = '0;
      return;
    end
    hs = exp_valid && out_ready;
    loaded = 1'b0;
    smp = 1'b0;
    if ($countones(an) == 1) begin
      if (an == last_an && seg == last_seg) run_len++;
      else run_len = 1;
      smp = (run_len == STABLE);
    end else begin
      run_len = 0;
    end
    last_an = an;
    last_seg = seg;
    if (smp) begin
      d = 0;
      for (int i = 0; i < DIGITS; i++) if (an[i]) d = i;
      ref_decode(seg, nib, e);
      m_nib[d] = nib;
      m_err[d] = e;
      m_seen[d] = 1'b1;
      if (&m_seen) begin
        m_seen = '0;
        if (!exp_valid || out_ready) begin
          for (int i = 0; i < DIGITS; i++) exp_bcd[4*i +: 4] = m_nib[i];
          exp_err = m_err;
          exp_valid = 1'b1;
          loaded = 1'b1;
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
    if (hs && !loaded) exp_valid = 1'b0;
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    if (chk_en) begin
      total++;
      if ({out_valid, overflow} !== {exp_valid, exp_ovf} ||
          (exp_valid && {bcd_out, err_glyph} !== {exp_bcd, exp_err})) begin
        bad++;
        $display("FAIL model t=%0t: got v=%b o=%b bcd=%h err=%b, want v=%b o=%b bcd=%h err=%b",
                 $time, out_valid, overflow, bcd_out, err_glyph, exp_valid, exp_ovf, exp_bcd, exp_err);
      end
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int hold);
    an = a;
    seg = s;
    for (int k = 0; k < hold; k++) cycle();
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        rdy;
    int          hold;
    logic        ev;
    logic        eo;
    logic        cd;
    logic [15:0] eb;
    logic [3:0]  ee;
  } vec_t;

  function automatic vec_t V(logic r, logic [3:0] a, logic [6:0] s, logic rd, int h,
                             logic ev, logic eo, logic cd, logic [15:0] eb, logic [3:0] ee);
    vec_t v;
    v.rst = r; v.an = a; v.seg = s; v.rdy = rd; v.hold = h;
    v.ev = ev; v.eo = eo; v.cd = cd; v.eb = eb; v.ee = ee;
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    // reset
    tbl.push_back(V(1, 4'b0000, 7'h00, 0, 2, 0, 0, 1, 16'h0000, 4'b0000));
    // basic frame, ready high
    tbl.push_back(V(0, 4'b0001, G1, 1, 6, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 4'b0010, G2, 1, 6, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 4'b0100, G3, 1, 6, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 4'b1000, G4, 1, 3, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 4'b1000, G4, 1, 1, 1, 0, 1, 16'h4321, 4'b0000));
    tbl.push_back(V(0, 4'b1000, G4, 1, 1, 0, 0, 0, 0, 0));
    // glitch on the completing digit restarts its count
    tbl.push_back(V(0, 4'b0001, G5, 1, 6, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 4'b0010, G6, 1, 6, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 4'b0100, G7, 1, 6, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 4'b1000, G8, 1, 3, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 4'b1000, G9, 1, 3, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 4'b1000, G9, 1, 1, 1, 0, 1, 16'h9765, 4'b0000));
    tbl.push_back(V(0, 4'b1000, G9, 1, 1, 0, 0, 0, 0, 0));
    // invalid glyph on digit 2
    tbl.push_back(V(0, 4'b0001, G0, 1, 6, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 4'b0010, G1, 1, 6, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 4'b0100, BADG, 1, 6, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 4'b1000, G2, 1, 4, 1, 0, 1, 16'h2F10, 4'b0100));
    tbl.push_back(V(0, 4'b1000, G2, 1, 1, 0, 0, 0, 0, 0));
    // backpressure: frame A held, frame B dropped
    tbl.push_back(V(0, 4'b0001, G1, 0, 6, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 4'b0010, G2, 0, 6, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 4'b0100, G3, 0, 6, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 4'b1000, G4, 0, 4, 1, 0, 1, 16'h4321, 4'b0000));
    tbl.push_back(V(0, 4'b1000, G4, 0, 2, 1, 0, 1, 16'h4321, 4'b0000));
    tbl.push_back(V(0, 4'b0001, G5, 0, 6, 1, 0, 1, 16'h4321, 4'b0000));
    tbl.push_back(V(0, 4'b0010, G6, 0, 6, 1, 0, 1, 16'h4321, 4'b0000));
    tbl.push_back(V(0, 4'b0100, G7, 0, 6, 1, 0, 1, 16'h4321, 4'b0000));
    tbl.push_back(V(0, 4'b1000, G8, 0, 4, 1, 1, 1, 16'h4321, 4'b0000));
    tbl.push_back(V(0, 4'b0000, 7'h00, 1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(V(0, 4'b0000, 7'h00, 1, 1, 0, 1, 0, 0, 0));
    // multi-hot strobes are idle and must not touch the working frame
    tbl.push_back(V(0, 4'b0001, G1, 1, 6, 0, 1, 0, 0, 0));
    tbl.push_back(V(0, 4'b0010, G2, 1, 6, 0, 1, 0, 0, 0));
    tbl.push_back(V(0, 4'b0100, G3, 1, 6, 0, 1, 0, 0, 0));
    tbl.push_back(V(0, 4'b1100, G8, 1, 10, 0, 1, 0, 0, 0));
    tbl.push_back(V(0, 4'b0011, G8, 1, 10, 0, 1, 0, 0, 0));
    tbl.push_back(V(0, 4'b1000, G4, 1, 4, 1, 1, 1, 16'h4321, 4'b0000));
    tbl.push_back(V(0, 4'b1000, G4, 1, 1, 0, 1, 0, 0, 0));
    // reset mid-frame discards the partial frame
    tbl.push_back(V(0, 4'b0001, G1, 1, 6, 0, 1, 0, 0, 0));
    tbl.push_back(V(0, 4'b0010, G2, 1, 6, 0, 1, 0, 0, 0));
    tbl.push_back(V(1, 4'b0000, 7'h00, 1, 1, 0, 0, 1, 16'h0000, 4'b0000));
    tbl.push_back(V(0, 4'b0100, G3, 1, 6, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 4'b1000, G4, 1, 6, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 4'b0001, G1, 1, 6, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 4'b0010, G2, 1, 4, 1, 0, 1, 16'h4321, 4'b0000));
    tbl.push_back(V(0, 4'b0010, G2, 1, 1, 0, 0, 0, 0, 0));

    rst = 1'b1; an = '0; seg = '0; out_ready = 1'b0;

    for (int r = 0; r < tbl.size(); r++) begin
      rst = tbl[r].rst;
      out_ready = tbl[r].rdy;
      drive(tbl[r].an, tbl[r].seg, tbl[r].hold);
      total++;
      if ({out_valid, overflow} !== {tbl[r].ev, tbl[r].eo}) begin
        bad++;
        $display("FAIL row%0d valid/ovf: got v=%b o=%b, want v=%b o=%b",
                 r, out_valid, overflow, tbl[r].ev, tbl[r].eo);
      end
      if (tbl[r].cd) begin
        total++;
        if ({bcd_out, err_glyph} !== {tbl[r].eb, tbl[r].ee}) begin
          bad++;
          $display("FAIL row%0d data: got bcd=%h err=%b, want bcd=%h err=%b",
                   r, bcd_out, err_glyph, tbl[r].eb, tbl[r].ee);
        end
      end
      $display("row %0d: rst=%b an=%b seg=%b rdy=%b hold=%0d -> v=%b o=%b bcd=%h err=%b",
               r, rst, an, seg, out_ready, tbl[r].hold, out_valid, overflow, bcd_out, err_glyph);
    end

    // alternate glyphs: decoded only when the option is built in
    rst = 1'b0;
    out_ready = 1'b1;
    drive(4'b0001, A6, 6);
    drive(4'b0010, A7, 6);
    drive(4'b0100, A9, 6);
    drive(4'b1000, G3, 4);
    begin
      logic [15:0] eb;
      logic [3:0]  ee;
`ifdef SEG7_ALT_GLYPH_EN
      eb = 16'h3976; ee = 4'b0000;
`else
      eb = 16'h3FFF; ee = 4'b0111;
`endif
      total++;
      if ({out_valid, bcd_out, err_glyph} !== {1'b1, eb, ee}) begin
        bad++;
        $display("FAIL alt_glyph: got v=%b bcd=%h err=%b, want v=1 bcd=%h err=%b",
                 out_valid, bcd_out, err_glyph, eb, ee);
      end
      $display("alt glyph frame: v=%b bcd=%h err=%b", out_valid, bcd_out, err_glyph);
    end
    drive(4'b1000, G3, 1);

    // randomized traffic against the reference model
    for (int n = 0; n < 500; n++) begin
      int pick;
      logic [3:0] a;
      logic [6:0] s;
      pick = $urandom_range(0, 99);
      if (pick < 80) a = 4'(1 << $urandom_range(0, DIGITS - 1));
      else if (pick < 90) a = 4'b0000;
      else a = 4'($urandom);
      if ($urandom_range(0, 99) < 75) s = POOL[$urandom_range(0, 13)];
      else s = 7'($urandom);
      out_ready = ($urandom_range(0, 99) < 70);
      rst = ($urandom_range(0, 199) == 0);
      drive(a, s, int'($urandom_range(1, 6)));
      if (n % 50 == 49)
        $display("random block %0d: v=%b o=%b bcd=%h err=%b", n / 50, out_valid, overflow, bcd_out, err_glyph);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
